// File: rtl/cpu_if_pkg.sv
// Shared definitions for the cpu instruction interface: word widths,
// flag bit positions and the dispatcher state encoding.
package cpu_if_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned FLAG_W  = 3;

  // Bit positions inside the packed {N,V,Z} flag field
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } disp_state_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO for the dispatcher. Power-of-two DEPTH, so the
// pointers wrap naturally. A push while full is dropped; the full flag
// comes from the registered count, so a pop in the same cycle does not
// make room for that push.
module instr_fifo
  import cpu_if_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       push_data,
  input  logic                     pop,
  output logic [INSTR_W-1:0]       head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count_q;
  logic               do_push;
  logic               do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array: written on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_instr_dispatcher.sv
// Instruction dispatcher: drains the instruction FIFO into the cpu one
// instruction at a time (s/load strobe, wait for w to fall then rise) and
// hands each result back through a single-entry valid/ready buffer.
// Optional watchdog: define DISPATCH_WATCHDOG_EN to abort an instruction
// that stays in WAIT_BUSY/WAIT_DONE for TIMEOUT cycles and raise sticky err.
module cpu_instr_dispatcher
  import cpu_if_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       push_data,
  output logic                     push_ready,
  output logic                     cpu_s,
  output logic                     cpu_load,
  output logic [INSTR_W-1:0]       cpu_in,
  input  logic [INSTR_W-1:0]       cpu_out,
  input  logic                     cpu_N,
  input  logic                     cpu_V,
  input  logic                     cpu_Z,
  input  logic                     cpu_w,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [INSTR_W-1:0]       res_data,
  output logic [FLAG_W-1:0]        res_flags,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     err
);

  disp_state_t        state;
  disp_state_t        state_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic               pop;
  logic               capture;
  logic               wd_expired;
  logic               wd_drop;

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_ready = !fifo_full;
  assign busy       = (state != IDLE);
  // Issue only when the result buffer is free and the cpu reports idle
  assign pop        = (state == IDLE) && !fifo_empty && !res_valid && cpu_w;

`ifdef DISPATCH_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_expired = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                      (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err        = err_q;

  // Watchdog counter restarts on every state entry; err is sticky
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_d != state) begin
        wd_cnt <= '0;
      end else if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_drop) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
  assign err            = 1'b0;
`endif

  // Next-state logic; a real cpu handshake always wins over the watchdog
  always_comb begin
    state_d = state;
    capture = 1'b0;
    wd_drop = 1'b0;
    case (state)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!cpu_w) begin
          state_d = WAIT_DONE;
        end else if (wd_expired) begin
          state_d = IDLE;
          wd_drop = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (cpu_w) begin
          state_d = IDLE;
          capture = 1'b1;
        end else if (wd_expired) begin
          state_d = IDLE;
          wd_drop = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered cpu strobes/instruction and the result buffer.
  // The strobes are registered from ISSUE, so they are seen by the cpu
  // during the first WAIT_BUSY cycle, two cycles after the push edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_s     <= 1'b0;
      cpu_load  <= 1'b0;
      cpu_in    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
    end else begin
      state    <= state_d;
      cpu_s    <= (state == ISSUE);
      cpu_load <= (state == ISSUE);
      if (pop) begin
        cpu_in <= fifo_head;
      end
      if (capture) begin
        res_data          <= cpu_out;
        res_flags[FLAG_N] <= cpu_N;
        res_flags[FLAG_V] <= cpu_V;
        res_flags[FLAG_Z] <= cpu_Z;
        res_valid         <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cpu_instr_dispatcher.md
Name: cpu_instr_dispatcher

Overview:
Hardware initiator for the cpu instruction interface (s/load/in, w/out/N/V/Z). A host pushes 16-bit instructions into a small FIFO. The dispatcher issues them one at a time to the cpu, waits for completion via w, and returns each result (out plus flags) over a valid/ready port. It replaces bench-driven instruction sequencing in system-level builds.

Parameters:
DEPTH, 4, instruction FIFO depth; power of two, minimum 2.
TIMEOUT, 8, watchdog limit in cycles (used only when the optional feature is compiled in).

Ports:
clk  in  1  clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
push  in  1  host writes push_data this cycle
push_data  in  16  instruction word
push_ready  out  1  FIFO not full
cpu_s  out  1  start strobe to cpu
cpu_load  out  1  instruction-register load to cpu
cpu_in  out  16  instruction to cpu
cpu_out  in  16  cpu datapath result
cpu_N  in  1  cpu negative flag
cpu_V  in  1  cpu overflow flag
cpu_Z  in  1  cpu zero flag
cpu_w  in  1  cpu waiting/idle
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_data  out  16  captured cpu_out
res_flags  out  3  captured {N,V,Z}
fifo_count  out  $clog2(DEPTH)+1  occupancy
busy  out  1  state != IDLE
err  out  1  sticky watchdog error (tied 0 when feature is absent)

Behaviour:
- Reset (reset_n=0 at posedge): FIFO flushed; state IDLE; all outputs 0 except push_ready=1. This holds from any state, including mid-instruction; cpu_s is low from the next edge.
- FIFO: a push is accepted when push && push_ready. push_ready = !full, computed from current state, so a push while full is dropped even if a pop occurs in the same cycle. A simultaneous push and pop when not full leaves count unchanged. Pointers wrap modulo DEPTH.
- Registered outputs: cpu_s, cpu_load and cpu_in are registered.
- IDLE: when count>0 && !res_valid && cpu_w, pop the head into cpu_in and go to ISSUE.
- ISSUE (1 cycle): cpu_s=1 and cpu_load=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until cpu_w==0, then go to WAIT_DONE.
- WAIT_DONE: on the first cycle with cpu_w==1, capture res_data<=cpu_out and res_flags<={cpu_N,cpu_V,cpu_Z}, set res_valid, and return to IDLE.
- res_valid holds until a cycle with res_ready=1, then clears on the next edge. While res_valid=1 no new instruction issues (single-entry result buffer, strict in-order).
- Latency: the earliest cpu_s is 2 cycles after the push edge. A new issue can start the cycle after a result is accepted.
- cpu_in keeps its last instruction between issues.

Optional Feature:
DISPATCH_WATCHDOG_EN
- Defined: a counter runs in WAIT_BUSY and WAIT_DONE and clears on each state entry. If it reaches TIMEOUT, the block sets err=1 (sticky until reset), drops the instruction without asserting res_valid, and returns to IDLE.
- Undefined: no counter; err tied 0; the block waits indefinitely.

Decomposition:
- Shared package cpu_if_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE), INSTR_W=16, FLAG_W=3, and flag bit indices N=2, V=1, Z=0.
- Sub-module instr_fifo (parameter DEPTH; push/pop/full/empty/count). The FSM lives in the top level.

Test Plan:
- Reset: hold reset_n=0 for 2 edges. All outputs 0, push_ready=1, fifo_count=0, busy=0.
- Program run against the real cpu: push 0xD103, 0xD207, 0xA269 with res_ready=1. Exactly 3 res_valid pulses occur in order, the third has res_data=0x000D, and cpu_s is a 1-cycle pulse each time.
- Backpressure: push 0xD103 and 0xD207, hold res_ready=0. After the first result, cpu_s stays 0, fifo_count=1 and res_data is stable. Raise res_ready; the second instruction issues within 2 cycles.
- Full/overflow with DEPTH=4 and cpu_w held 0: push 5 words. push_ready drops after the 4th, the 5th is ignored, and fifo_count=4.
- Reset during WAIT_DONE: next edge gives fifo_count=0, res_valid=0, busy=0, cpu_s=0. Pushes afterward work normally.
- Watchdog (macro defined, TIMEOUT=8) with cpu_w tied 1 after issue: err=1 within 9 cycles of cpu_s, res_valid stays 0, state returns to IDLE. Without the macro, err stays 0 and busy stays 1.
